tick_timer_multi: RTL and testbench

Parametrised multi-channel tick generator, the successor to the fixed single-channel 0.25 s timer. Each of CH independent channels has a runtime-programmable period, a periodic or one-shot mode, start/stop control, a one-cycle tick pulse and a sticky done flag. It sits beside the UART counter datapath and supplies all of its timebase and timeout pulses from the one clk_in domain.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/tick_chan.sv | 92 +++++++++
 rtl/tick_timer_multi.sv | 50 +++++
 tb/tb_tick_timer_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel tick timer.
// Holds the mode/state encodings and the effective-period rule.
package timer_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest period the helper handles; callers cast to their own width.
    localparam int PW = 32;

    // A period of zero is treated as one so the channel still ticks every cycle.
    function automatic logic [PW-1:0] p_eff(input logic [PW-1:0] period);
        return (period == '0) ? PW'(1) : period;
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One timer channel: period/mode config registers, IDLE/RUN control and
// the up-counter that produces the registered tick and sticky done.
module tick_chan
    import timer_pkg::*;
#(
    parameter int          CW         = 16,
    parameter int unsigned DEF_PERIOD = 2400
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_period,
    input  logic          wr_mode,
    input  logic          start,
    input  logic          stop,
    input  logic          done_clr,
    output logic          tick,
    output logic          busy,
    output logic          done
);

    logic [CW-1:0] period_reg;
    logic [CW-1:0] act_period;
    logic [CW-1:0] count;
    logic [CW-1:0] cfg_period;
    mode_t         mode_reg;
    mode_t         act_mode;
    mode_t         cfg_mode;
    state_t        state;
    logic          terminal;
    logic          tick_set;

    // A same-edge write is visible to any reload happening on that edge.
    always_comb begin
        cfg_period = wr_en ? wr_period : period_reg;
        cfg_mode   = wr_en ? mode_t'(wr_mode) : mode_reg;
        terminal   = (state == ST_RUN) && (count == act_period - CW'(1));
        tick_set   = terminal && !stop;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            period_reg <= CW'(DEF_PERIOD);
            mode_reg   <= MODE_PERIODIC;
        end else if (wr_en) begin
            period_reg <= wr_period;
            mode_reg   <= mode_t'(wr_mode);
        end
    end

    // Priority: stop, then (re)start, then terminal count, then counting.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            act_period <= CW'(DEF_PERIOD);
            act_mode   <= MODE_PERIODIC;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tick <= tick_set;
            if (stop) begin
                state <= ST_IDLE;
                count <= '0;
            end else if (start) begin
                state      <= ST_RUN;
                count      <= '0;
                act_period <= CW'(p_eff(PW'(cfg_period)));
                act_mode   <= cfg_mode;
            end else if (terminal) begin
                count <= '0;
                if (act_mode == MODE_PERIODIC) begin
                    act_period <= CW'(p_eff(PW'(cfg_period)));
                    act_mode   <= cfg_mode;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (state == ST_RUN) begin
                count <= count + CW'(1);
            end

            if (tick_set) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: rtl/tick_timer_multi.sv
// Multi-channel tick generator: decodes the shared config write port onto
// CH independent tick_chan instances.
module tick_timer_multi
    import timer_pkg::*;
#(
    parameter int          CH         = 4,
    parameter int          CW         = 16,
    parameter int unsigned DEF_PERIOD = 2400
) (
    input  logic                                  clk_in,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] wr_ch,
    input  logic [CW-1:0]                         wr_period,
    input  logic                                  wr_mode,
    input  logic [CH-1:0]                         start,
    input  logic [CH-1:0]                         stop,
    input  logic [CH-1:0]                         done_clr,
    output logic [CH-1:0]                         tick,
    output logic [CH-1:0]                         busy,
    output logic [CH-1:0]                         done
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    // Channel numbers at or above CH never match, so such writes are dropped.
    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic chan_wr;

        assign chan_wr = wr_en && (wr_ch == CHW'(i));

        tick_chan #(
            .CW         (CW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk_in    (clk_in),
            .reset     (reset),
            .wr_en     (chan_wr),
            .wr_period (wr_period),
            .wr_mode   (wr_mode),
            .start     (start[i]),
            .stop      (stop[i]),
            .done_clr  (done_clr[i]),
            .tick      (tick[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_tick_timer_multi.sv
// Bench for tick_timer_multi: a deadline-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_tick_timer_multi;

    localparam int CH         = 4;
    localparam int CW         = 16;
    localparam int DEF_PERIOD = 2400;

    logic          clk_in = 1'b0;
    logic          reset  = 1'b1;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_period;
    logic          wr_mode;
    logic [CH-1:0] start;
    logic [CH-1:0] stop;
    logic [CH-1:0] done_clr;
    logic [CH-1:0] tick;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;

    int checks   = 0;
    int failures = 0;

    tick_timer_multi #(
        .CH         (CH),
        .CW         (CW),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_period (wr_period),
        .wr_mode   (wr_mode),
        .start     (start),
        .stop      (stop),
        .done_clr  (done_clr),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_in = ~clk_in;

    // Model: each running channel holds the absolute edge number of its next expiry.
    int            cyc = 0;
    bit            m_run[CH];
    int            m_deadline[CH];
    int            m_period[CH];
    bit            m_mode[CH];
    bit            m_amode[CH];
    logic [CH-1:0] m_tick = '0;
    logic [CH-1:0] m_done = '0;

    always @(posedge clk_in or negedge reset) begin
        bit hit;
        bit wrap;
        bit cm;
        int cp;
        if (!reset) begin
            cyc    = 0;
            m_tick = '0;
            m_done = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c]      = 1'b0;
                m_deadline[c] = 0;
                m_period[c]   = DEF_PERIOD;
                m_mode[c]     = 1'b0;
                m_amode[c]    = 1'b0;
            end
        end else begin
            cyc++;
            for (int c = 0; c < CH; c++) begin
                hit       = wr_en && (int'(wr_ch) == c);
                cp        = hit ? int'(wr_period) : m_period[c];
                cm        = hit ? wr_mode : m_mode[c];
                wrap      = m_run[c] && (cyc == m_deadline[c]);
                m_tick[c] = 1'b0;
                if (stop[c]) begin
                    m_run[c] = 1'b0;
                end else if (start[c]) begin
                    m_tick[c]     = wrap;
                    m_run[c]      = 1'b1;
                    m_deadline[c] = cyc + ((cp == 0) ? 1 : cp);
                    m_amode[c]    = cm;
                end else if (wrap) begin
                    m_tick[c] = 1'b1;
                    if (!m_amode[c]) begin
                        m_deadline[c] = cyc + ((cp == 0) ? 1 : cp);
                        m_amode[c]    = cm;
                    end else begin
                        m_run[c] = 1'b0;
                    end
                end
                if (m_tick[c]) m_done[c] = 1'b1;
                else if (done_clr[c]) m_done[c] = 1'b0;
                if (hit) begin
                    m_period[c] = cp;
                    m_mode[c]   = cm;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        logic [CH-1:0] m_busy;
        for (int c = 0; c < CH; c++) m_busy[c] = m_run[c];
        checks += 3;
        if (tick !== m_tick) begin
            failures++;
            $display("[TB] FAIL model_tick cyc=%0d got=%b expected=%b", cyc, tick, m_tick);
        end
        if (busy !== m_busy) begin
            failures++;
            $display("[TB] FAIL model_busy cyc=%0d got=%b expected=%b", cyc, busy, m_busy);
        end
        if (done !== m_done) begin
            failures++;
            $display("[TB] FAIL model_done cyc=%0d got=%b expected=%b", cyc, done, m_done);
        end
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%b expected=%b", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, lets one edge sample them, then idles the pulses.
    task automatic applyStimulus(input logic we, input logic [1:0] ch, input logic [CW-1:0] per,
                                 input logic md, input logic [CH-1:0] st, input logic [CH-1:0] sp,
                                 input logic [CH-1:0] dc);
        wr_en     = we;
        wr_ch     = ch;
        wr_period = per;
        wr_mode   = md;
        start     = st;
        stop      = sp;
        done_clr  = dc;
        @(posedge clk_in);
        #1;
        wr_en    = 1'b0;
        start    = '0;
        stop     = '0;
        done_clr = '0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_period = '0;
        wr_mode   = 1'b0;
        start     = '0;
        stop      = '0;
        done_clr  = '0;

        #2 reset = 1'b0;
        repeat (2) @(posedge clk_in);
        #3 reset = 1'b1;
        @(posedge clk_in);
        #1;
        checkOutput("reset_tick", |tick, 1'b0);
        checkOutput("reset_busy", |busy, 1'b0);
        checkOutput("reset_done", |done, 1'b0);

        // Channel 0, default period, periodic.
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        checkOutput("ch0_busy_rise", busy[0], 1'b1);
        checkOutput("ch0_no_early_tick", tick[0], 1'b0);
        for (int k = 1; k <= 3; k++) begin
            waitCycles(DEF_PERIOD - 1);
            checkOutput("ch0_pre_tick", tick[0], 1'b0);
            waitCycles(1);
            checkOutput("ch0_tick", tick[0], 1'b1);
            checkOutput("ch0_done", done[0], 1'b1);
            checkOutput("ch0_busy_held", busy[0], 1'b1);
        end

        // Channel 1, period 5, one-shot.
        applyStimulus(1'b1, 2'd1, 16'd5, 1'b1, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0010, 4'b0000, 4'b0000);
        checkOutput("ch1_busy_rise", busy[1], 1'b1);
        waitCycles(4);
        checkOutput("ch1_pre_tick", tick[1], 1'b0);
        checkOutput("ch1_busy_before", busy[1], 1'b1);
        waitCycles(1);
        checkOutput("ch1_tick", tick[1], 1'b1);
        checkOutput("ch1_busy_fall", busy[1], 1'b0);
        waitCycles(10);
        checkOutput("ch1_no_retick", tick[1], 1'b0);

        // Channel 2, period 0 ticks every cycle; then period 3 after the next reload.
        applyStimulus(1'b1, 2'd2, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0100, 4'b0000, 4'b0000);
        checkOutput("ch2_first_cycle", tick[2], 1'b0);
        waitCycles(1);
        checkOutput("ch2_tick_a", tick[2], 1'b1);
        waitCycles(1);
        checkOutput("ch2_tick_b", tick[2], 1'b1);
        applyStimulus(1'b1, 2'd2, 16'd3, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("ch2_tick_at_write", tick[2], 1'b1);
        waitCycles(1);
        checkOutput("ch2_gap_1", tick[2], 1'b0);
        waitCycles(1);
        checkOutput("ch2_gap_2", tick[2], 1'b0);
        waitCycles(1);
        checkOutput("ch2_tick_p3", tick[2], 1'b1);
        waitCycles(3);
        checkOutput("ch2_tick_p3_again", tick[2], 1'b1);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0000, 4'b0100, 4'b0000);
        checkOutput("ch2_stopped", busy[2], 1'b0);

        // Channel 0 restarted at period 10; stop+start land on the terminal edge.
        applyStimulus(1'b1, 2'd0, 16'd10, 1'b0, 4'b0001, 4'b0000, 4'b0001);
        checkOutput("ch0_restart_busy", busy[0], 1'b1);
        checkOutput("ch0_done_cleared", done[0], 1'b0);
        waitCycles(9);
        checkOutput("ch0_count9_no_tick", tick[0], 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0001, 4'b0001, 4'b0000);
        checkOutput("ch0_stop_no_tick", tick[0], 1'b0);
        checkOutput("ch0_stop_idle", busy[0], 1'b0);
        checkOutput("ch0_stop_no_done", done[0], 1'b0);
        waitCycles(12);
        checkOutput("ch0_stays_idle", busy[0], 1'b0);

        // Channel 3: done_clr coinciding with a tick loses to the set.
        applyStimulus(1'b1, 2'd3, 16'd4, 1'b0, 4'b0000, 4'b0000, 4'b0000);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b1000, 4'b0000, 4'b0000);
        waitCycles(3);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0000, 4'b0000, 4'b1000);
        checkOutput("ch3_tick", tick[3], 1'b1);
        checkOutput("ch3_set_wins", done[3], 1'b1);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0000, 4'b0000, 4'b1000);
        checkOutput("ch3_clr", done[3], 1'b0);
        checkOutput("ch3_tick_single", tick[3], 1'b0);

        // Reset in mid-run clears everything immediately.
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        waitCycles(5);
        checkOutput("pre_reset_busy0", busy[0], 1'b1);
        checkOutput("pre_reset_busy3", busy[3], 1'b1);
        checkOutput("pre_reset_done3", done[3], 1'b1);
        reset = 1'b0;
        #2;
        checkOutput("async_tick", |tick, 1'b0);
        checkOutput("async_busy", |busy, 1'b0);
        checkOutput("async_done", |done, 1'b0);
        waitCycles(3);
        checkOutput("held_busy", |busy, 1'b0);
        #1 reset = 1'b1;
        @(posedge clk_in);
        #1;
        waitCycles(20);
        checkOutput("post_reset_idle", |busy, 1'b0);
        checkOutput("post_reset_no_tick", |tick, 1'b0);
        applyStimulus(1'b0, 2'd0, '0, 1'b0, 4'b0001, 4'b0000, 4'b0000);
        waitCycles(DEF_PERIOD - 1);
        checkOutput("post_reset_pre_tick", tick[0], 1'b0);
        waitCycles(1);
        checkOutput("post_reset_def_period", tick[0], 1'b1);

        waitCycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
